// File: rtl/pcie_us_cfg_mgmt_arb_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pcie_us_cfg_mgmt_arb_pkg: shared types and widths for the cfg_mgmt arbiter.
// Rev 1.0
// ----------------------------------------------------------------------------
package pcie_us_cfg_mgmt_arb_pkg;

  localparam int CFG_ADDR_W = 10;
  localparam int CFG_FUNC_W = 8;
  localparam int CFG_DATA_W = 32;
  localparam int CFG_BE_W   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/pcie_us_cfg_mgmt_arb_rr.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pcie_rr_arb: combinational round-robin picker; search starts after i_last.
// Rev 1.0
// ----------------------------------------------------------------------------
module pcie_rr_arb #(
  parameter int PORTS = 2,
  parameter int IDX_W = 1
) (
  input  logic [PORTS-1:0] i_req,
  input  logic [IDX_W-1:0] i_last,
  output logic [PORTS-1:0] o_grant,
  output logic [IDX_W-1:0] o_idx
);

  logic w_found;
  int   w_pos;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_pos   = 0;
    for (int i = 1; i <= PORTS; i++) begin
      w_pos = int'(i_last) + i;
      if (w_pos >= PORTS) w_pos = w_pos - PORTS;
      if (!w_found && i_req[w_pos]) begin
        w_found        = 1'b1;
        o_grant[w_pos] = 1'b1;
        o_idx          = IDX_W'(w_pos);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/pcie_us_cfg_mgmt_arb.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pcie_us_cfg_mgmt_arb: shares the UltraScale PCIe cfg_mgmt port among PORTS
// requesters, one transaction at a time. Optional: PCIE_US_CFG_MGMT_ARB_TIMEOUT_EN.
// Rev 1.0
// ----------------------------------------------------------------------------
module pcie_us_cfg_mgmt_arb
  import pcie_us_cfg_mgmt_arb_pkg::*;
#(
  parameter int PORTS   = 2,
  parameter int TIMEOUT = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [PORTS-1:0]              s_req_valid,
  output logic [PORTS-1:0]              s_req_ready,
  input  logic [PORTS*CFG_ADDR_W-1:0]   s_req_addr,
  input  logic [PORTS*CFG_FUNC_W-1:0]   s_req_function_number,
  input  logic [PORTS-1:0]              s_req_write,
  input  logic [PORTS*CFG_DATA_W-1:0]   s_req_write_data,
  input  logic [PORTS*CFG_BE_W-1:0]     s_req_byte_enable,
  output logic [PORTS-1:0]              s_resp_valid,
  output logic [CFG_DATA_W-1:0]         s_resp_data,
  output logic [PORTS-1:0]              s_resp_error,
  output logic [CFG_ADDR_W-1:0]         cfg_mgmt_addr,
  output logic [CFG_FUNC_W-1:0]         cfg_mgmt_function_number,
  output logic                          cfg_mgmt_write,
  output logic [CFG_DATA_W-1:0]         cfg_mgmt_write_data,
  output logic [CFG_BE_W-1:0]           cfg_mgmt_byte_enable,
  output logic                          cfg_mgmt_read,
  input  logic [CFG_DATA_W-1:0]         cfg_mgmt_read_data,
  input  logic                          cfg_mgmt_read_write_done
);

  localparam int IDX_W = (PORTS > 1) ? $clog2(PORTS) : 1;
  localparam logic [IDX_W-1:0] c_last_port = IDX_W'(PORTS - 1);

  state_t                 r_state, w_state_nxt;
  logic [IDX_W-1:0]       r_last, r_owner, w_idx;
  logic [PORTS-1:0]       w_grant;
  logic                   w_accept, w_done, w_timeout;
  logic [CFG_ADDR_W-1:0]  r_addr, w_sel_addr;
  logic [CFG_FUNC_W-1:0]  r_func, w_sel_func;
  logic [CFG_DATA_W-1:0]  r_wdata, w_sel_wdata, r_resp_data;
  logic [CFG_BE_W-1:0]    r_be, w_sel_be;
  logic                   r_rd, r_wr, w_sel_wr;

  pcie_rr_arb #(
    .PORTS (PORTS),
    .IDX_W (IDX_W)
  ) u_rr (
    .i_req   (s_req_valid),
    .i_last  (r_last),
    .o_grant (w_grant),
    .o_idx   (w_idx)
  );

  assign w_accept    = (r_state == IDLE) && (|s_req_valid);
  assign w_done      = (r_state == BUSY) && cfg_mgmt_read_write_done;
  // Ready is masked during reset so nothing is accepted while the block is held.
  assign s_req_ready = ((r_state == IDLE) && !rst) ? w_grant : '0;

  assign w_sel_addr  = s_req_addr[int'(w_idx)*CFG_ADDR_W +: CFG_ADDR_W];
  assign w_sel_func  = s_req_function_number[int'(w_idx)*CFG_FUNC_W +: CFG_FUNC_W];
  assign w_sel_wdata = s_req_write_data[int'(w_idx)*CFG_DATA_W +: CFG_DATA_W];
  assign w_sel_be    = s_req_byte_enable[int'(w_idx)*CFG_BE_W +: CFG_BE_W];
  assign w_sel_wr    = s_req_write[w_idx];

`ifdef PCIE_US_CFG_MGMT_ARB_TIMEOUT_EN
  logic [15:0] r_cnt;
  logic        r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      if (w_accept)
        r_cnt <= '0;
      else if (r_state == BUSY)
        r_cnt <= r_cnt + 16'd1;
      // done takes precedence over a simultaneous timeout
      if (w_done)
        r_err <= 1'b0;
      else if (w_timeout)
        r_err <= 1'b1;
    end
  end

  assign w_timeout    = (r_state == BUSY) && (r_cnt == 16'(TIMEOUT - 1));
  assign s_resp_error = r_err ? s_resp_valid : '0;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT != 0);
  assign w_timeout        = 1'b0;
  assign s_resp_error     = '0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (|s_req_valid) w_state_nxt = BUSY;
      BUSY:    if (cfg_mgmt_read_write_done || w_timeout) w_state_nxt = RESP;
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_last      <= c_last_port;
      r_owner     <= '0;
      r_addr      <= '0;
      r_func      <= '0;
      r_wdata     <= '0;
      r_be        <= '0;
      r_rd        <= 1'b0;
      r_wr        <= 1'b0;
      r_resp_data <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_owner <= w_idx;
        r_last  <= w_idx;
        r_addr  <= w_sel_addr;
        r_func  <= w_sel_func;
        r_wdata <= w_sel_wdata;
        r_be    <= w_sel_be;
        r_rd    <= !w_sel_wr;
        r_wr    <= w_sel_wr;
      end else if (w_done) begin
        r_rd        <= 1'b0;
        r_wr        <= 1'b0;
        r_resp_data <= r_rd ? cfg_mgmt_read_data : '0;
      end else if (w_timeout) begin
        r_rd        <= 1'b0;
        r_wr        <= 1'b0;
        r_resp_data <= '1;
      end
    end
  end

  always_comb begin
    s_resp_valid = '0;
    if (r_state == RESP) s_resp_valid[r_owner] = 1'b1;
  end

  assign s_resp_data              = r_resp_data;
  assign cfg_mgmt_addr            = r_addr;
  assign cfg_mgmt_function_number = r_func;
  assign cfg_mgmt_write_data      = r_wdata;
  assign cfg_mgmt_byte_enable     = r_be;
  assign cfg_mgmt_read            = r_rd;
  assign cfg_mgmt_write           = r_wr;

endmodule
`default_nettype wire

// File: tb/tb_pcie_us_cfg_mgmt_arb.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_pcie_us_cfg_mgmt_arb: directed scenarios plus a randomized run against a
// transaction-level round-robin model.
// ----------------------------------------------------------------------------
module tb_pcie_us_cfg_mgmt_arb;

  localparam int PORTS   = 3;
  localparam int TIMEOUT = 16;

  logic                  clk, rst;
  logic [PORTS-1:0]      s_req_valid, s_req_ready, s_req_write;
  logic [PORTS*10-1:0]   s_req_addr;
  logic [PORTS*8-1:0]    s_req_function_number;
  logic [PORTS*32-1:0]   s_req_write_data;
  logic [PORTS*4-1:0]    s_req_byte_enable;
  logic [PORTS-1:0]      s_resp_valid, s_resp_error;
  logic [31:0]           s_resp_data;
  logic [9:0]            cfg_mgmt_addr;
  logic [7:0]            cfg_mgmt_function_number;
  logic                  cfg_mgmt_write, cfg_mgmt_read;
  logic [31:0]           cfg_mgmt_write_data;
  logic [3:0]            cfg_mgmt_byte_enable;
  logic [31:0]           cfg_mgmt_read_data;
  logic                  cfg_mgmt_read_write_done;

  int errors = 0;
  int checks = 0;

  // random-run model state
  logic [PORTS-1:0] m_pend;
  logic             m_wr   [PORTS];
  logic [9:0]       m_addr [PORTS];
  logic [7:0]       m_func [PORTS];
  logic [31:0]      m_data [PORTS];
  logic [3:0]       m_be   [PORTS];

  pcie_us_cfg_mgmt_arb #(
    .PORTS   (PORTS),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk                      (clk),
    .rst                      (rst),
    .s_req_valid              (s_req_valid),
    .s_req_ready              (s_req_ready),
    .s_req_addr               (s_req_addr),
    .s_req_function_number    (s_req_function_number),
    .s_req_write              (s_req_write),
    .s_req_write_data         (s_req_write_data),
    .s_req_byte_enable        (s_req_byte_enable),
    .s_resp_valid             (s_resp_valid),
    .s_resp_data              (s_resp_data),
    .s_resp_error             (s_resp_error),
    .cfg_mgmt_addr            (cfg_mgmt_addr),
    .cfg_mgmt_function_number (cfg_mgmt_function_number),
    .cfg_mgmt_write           (cfg_mgmt_write),
    .cfg_mgmt_write_data      (cfg_mgmt_write_data),
    .cfg_mgmt_byte_enable     (cfg_mgmt_byte_enable),
    .cfg_mgmt_read            (cfg_mgmt_read),
    .cfg_mgmt_read_data       (cfg_mgmt_read_data),
    .cfg_mgmt_read_write_done (cfg_mgmt_read_write_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [PORTS-1:0] onehot(input int k);
    logic [PORTS-1:0] v;
    v = '0;
    if (k >= 0) v[k] = 1'b1;
    return v;
  endfunction

  function automatic int rr_pick(input logic [PORTS-1:0] pend, input int last);
    for (int i = 1; i <= PORTS; i++) begin
      if (pend[(last + i) % PORTS]) return (last + i) % PORTS;
    end
    return -1;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    s_req_valid = '0;
    s_req_write = '0;
    s_req_addr = '0;
    s_req_function_number = '0;
    s_req_write_data = '0;
    s_req_byte_enable = '0;
    cfg_mgmt_read_data = '0;
    cfg_mgmt_read_write_done = 1'b0;
  endtask

  task automatic set_req(input int p, input logic wr, input logic [9:0] a,
                         input logic [7:0] f, input logic [31:0] d, input logic [3:0] be);
    s_req_valid[p] = 1'b1;
    s_req_write[p] = wr;
    s_req_addr[p*10 +: 10] = a;
    s_req_function_number[p*8 +: 8] = f;
    s_req_write_data[p*32 +: 32] = d;
    s_req_byte_enable[p*4 +: 4] = be;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b0;
    #1;
    rst = 1'b1;
    s_req_valid = '1;
    #2;
    checks++; if (s_req_ready !== '0) begin errors++; $display("FAIL reset_ready: got %b want 0", s_req_ready); end
    checks++; if (s_resp_valid !== '0 || s_resp_error !== '0) begin errors++; $display("FAIL reset_resp: got valid %b err %b want 0", s_resp_valid, s_resp_error); end
    checks++; if (s_resp_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 0", s_resp_data); end
    checks++; if (cfg_mgmt_read !== 1'b0 || cfg_mgmt_write !== 1'b0) begin errors++; $display("FAIL reset_rw: got rd %b wr %b want 0", cfg_mgmt_read, cfg_mgmt_write); end
    checks++; if ({cfg_mgmt_addr, cfg_mgmt_function_number, cfg_mgmt_write_data, cfg_mgmt_byte_enable} !== '0) begin errors++;
      $display("FAIL reset_fields: got addr %h func %h data %h be %h want 0", cfg_mgmt_addr, cfg_mgmt_function_number, cfg_mgmt_write_data, cfg_mgmt_byte_enable); end
    do_reset();
  endtask

  task automatic test_single_read();
    int rd_cycles = 0;
    int pulses = 0;
    do_reset();
    set_req(0, 1'b0, 10'h032, 8'h00, 32'h0, 4'h0);
    sample();
    checks++; if (s_req_ready !== 3'b001) begin errors++; $display("FAIL read_grant: got %b want 001", s_req_ready); end
    if (s_req_ready[0]) pulses++;
    for (int k = 1; k <= 4; k++) begin
      next_cycle();
      if (k == 1) s_req_valid[0] = 1'b0;
      if (k == 4) begin cfg_mgmt_read_write_done = 1'b1; cfg_mgmt_read_data = 32'h00002910; end
      sample();
      if (cfg_mgmt_read) rd_cycles++;
      if (s_req_ready[0]) pulses++;
    end
    next_cycle();
    cfg_mgmt_read_write_done = 1'b0;
    cfg_mgmt_read_data = 32'hBAD0BAD0;
    sample();
    if (s_req_ready[0]) pulses++;
    checks++; if (rd_cycles != 4 || cfg_mgmt_read !== 1'b0) begin errors++; $display("FAIL read_strobe: got %0d cycles rd_now %b want 4 and 0", rd_cycles, cfg_mgmt_read); end
    checks++; if (pulses != 1) begin errors++; $display("FAIL read_ready_pulses: got %0d want 1", pulses); end
    checks++; if (s_resp_valid !== 3'b001 || s_resp_data !== 32'h00002910 || s_resp_error !== '0) begin errors++;
      $display("FAIL read_resp: got valid %b data %h err %b want 001 00002910 000", s_resp_valid, s_resp_data, s_resp_error); end
    next_cycle();
  endtask

  task automatic test_contention();
    int order[4] = '{0, 1, 0, 1};
    bit overlap = 0;
    bit got;
    do_reset();
    set_req(0, 1'b0, 10'h100, 8'h01, 32'h0, 4'h0);
    set_req(1, 1'b0, 10'h101, 8'h02, 32'h0, 4'h0);
    for (int n = 0; n < 4; n++) begin
      got = 0;
      for (int c = 0; c < 8; c++) begin
        sample();
        if (s_req_ready != '0) begin got = 1; break; end
        next_cycle();
      end
      checks++; if (!got || s_req_ready !== onehot(order[n])) begin errors++;
        $display("FAIL contention_grant%0d: got %b want %b", n, s_req_ready, onehot(order[n])); end
      next_cycle();
      cfg_mgmt_read_write_done = 1'b1;
      cfg_mgmt_read_data = 32'h1000 + n;
      sample();
      if (cfg_mgmt_read && cfg_mgmt_write) overlap = 1;
      next_cycle();
      cfg_mgmt_read_write_done = 1'b0;
      sample();
      if (cfg_mgmt_read && cfg_mgmt_write) overlap = 1;
      checks++; if (s_resp_valid !== onehot(order[n]) || s_resp_data !== 32'h1000 + n) begin errors++;
        $display("FAIL contention_resp%0d: got %b %h want %b %h", n, s_resp_valid, s_resp_data, onehot(order[n]), 32'h1000 + n); end
      next_cycle();
    end
    checks++; if (overlap) begin errors++; $display("FAIL contention_rw_overlap: got 1 want 0"); end
    clear_inputs();
    next_cycle();
  endtask

  task automatic test_write();
    bit stable = 1;
    clear_inputs();
    set_req(1, 1'b1, 10'h0AB, 8'd64, 32'hDEADBEEF, 4'b0011);
    sample();
    checks++; if (s_req_ready !== 3'b010) begin errors++; $display("FAIL write_grant: got %b want 010", s_req_ready); end
    for (int k = 1; k <= 3; k++) begin
      next_cycle();
      if (k == 1) s_req_valid[1] = 1'b0;
      if (k == 3) begin cfg_mgmt_read_write_done = 1'b1; cfg_mgmt_read_data = 32'h12345678; end
      sample();
      if (cfg_mgmt_write_data !== 32'hDEADBEEF || cfg_mgmt_byte_enable !== 4'b0011 || cfg_mgmt_function_number !== 8'd64 ||
          cfg_mgmt_addr !== 10'h0AB || cfg_mgmt_write !== 1'b1 || cfg_mgmt_read !== 1'b0) stable = 0;
    end
    next_cycle();
    cfg_mgmt_read_write_done = 1'b0;
    sample();
    checks++; if (!stable) begin errors++; $display("FAIL write_stable: got unstable fields want stable"); end
    checks++; if (s_resp_valid !== 3'b010 || s_resp_data !== 32'h0 || cfg_mgmt_write !== 1'b0) begin errors++;
      $display("FAIL write_resp: got valid %b data %h wr %b want 010 0 0", s_resp_valid, s_resp_data, cfg_mgmt_write); end
    next_cycle();
  endtask

`ifdef PCIE_US_CFG_MGMT_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int cnt = 0;
    clear_inputs();
    set_req(0, 1'b0, 10'h010, 8'h00, 32'h0, 4'h0);
    sample();
    for (int c = 0; c < 40; c++) begin
      next_cycle();
      s_req_valid[0] = 1'b0;
      sample();
      if (cfg_mgmt_read) cnt++;
      else break;
    end
    checks++; if (cnt != 16) begin errors++; $display("FAIL timeout_len: got %0d want 16", cnt); end
    checks++; if (s_resp_valid !== 3'b001 || s_resp_error !== 3'b001 || s_resp_data !== 32'hFFFFFFFF) begin errors++;
      $display("FAIL timeout_resp: got %b %b %h want 001 001 ffffffff", s_resp_valid, s_resp_error, s_resp_data); end
    next_cycle();
    set_req(0, 1'b0, 10'h011, 8'h00, 32'h0, 4'h0);
    sample();
    for (int k = 1; k <= 16; k++) begin
      next_cycle();
      s_req_valid[0] = 1'b0;
      if (k == 16) begin cfg_mgmt_read_write_done = 1'b1; cfg_mgmt_read_data = 32'h0000A5A5; end
      sample();
    end
    next_cycle();
    cfg_mgmt_read_write_done = 1'b0;
    sample();
    checks++; if (s_resp_valid !== 3'b001 || s_resp_error !== '0 || s_resp_data !== 32'h0000A5A5) begin errors++;
      $display("FAIL timeout_done_wins: got %b %b %h want 001 000 0000a5a5", s_resp_valid, s_resp_error, s_resp_data); end
    next_cycle();
  endtask
`endif

  task automatic test_reset_mid_busy();
    bit stray = 0;
    clear_inputs();
    set_req(0, 1'b0, 10'h155, 8'h03, 32'h0, 4'h0);
    sample();
    next_cycle();
    s_req_valid[0] = 1'b0;
    sample();
    checks++; if (cfg_mgmt_read !== 1'b1) begin errors++; $display("FAIL rstbusy_pre: got rd %b want 1", cfg_mgmt_read); end
    #1 rst = 1'b1;
    #1;
    checks++; if (cfg_mgmt_read !== 1'b0 || cfg_mgmt_addr !== 10'h0) begin errors++;
      $display("FAIL rstbusy_async: got rd %b addr %h want 0 0", cfg_mgmt_read, cfg_mgmt_addr); end
    next_cycle();
    rst = 1'b0;
    cfg_mgmt_read_write_done = 1'b1;
    cfg_mgmt_read_data = 32'h77777777;
    sample();
    if (s_resp_valid != '0) stray = 1;
    for (int c = 0; c < 4; c++) begin
      next_cycle();
      cfg_mgmt_read_write_done = 1'b0;
      sample();
      if (s_resp_valid != '0 || cfg_mgmt_read || cfg_mgmt_write) stray = 1;
    end
    checks++; if (stray) begin errors++; $display("FAIL rstbusy_stray: got activity after reset want none"); end
    next_cycle();
    set_req(1, 1'b0, 10'h001, 8'h00, 32'h0, 4'h0);
    set_req(0, 1'b0, 10'h002, 8'h00, 32'h0, 4'h0);
    sample();
    checks++; if (s_req_ready !== 3'b001) begin errors++; $display("FAIL rstbusy_ptr: got %b want 001", s_req_ready); end
    next_cycle();
    clear_inputs();
    cfg_mgmt_read_write_done = 1'b1;
    next_cycle();
    cfg_mgmt_read_write_done = 1'b0;
    next_cycle();
  endtask

  task automatic test_withdrawn();
    bit bad = 0;
    clear_inputs();
    set_req(0, 1'b0, 10'h044, 8'h00, 32'h0, 4'h0);
    sample();
    checks++; if (s_req_ready !== 3'b001) begin errors++; $display("FAIL withdraw_grant0: got %b want 001", s_req_ready); end
    for (int k = 1; k <= 4; k++) begin
      next_cycle();
      if (k == 1) s_req_valid[0] = 1'b0;
      if (k == 2) set_req(1, 1'b0, 10'h045, 8'h00, 32'h0, 4'h0);
      if (k == 3) s_req_valid[1] = 1'b0;
      if (k == 4) begin cfg_mgmt_read_write_done = 1'b1; cfg_mgmt_read_data = 32'h44; end
      sample();
      if (s_req_ready[1] || s_resp_valid[1]) bad = 1;
    end
    next_cycle();
    cfg_mgmt_read_write_done = 1'b0;
    sample();
    checks++; if (s_resp_valid !== 3'b001) begin errors++; $display("FAIL withdraw_resp0: got %b want 001", s_resp_valid); end
    for (int c = 0; c < 4; c++) begin
      next_cycle();
      sample();
      if (s_req_ready != '0 || s_resp_valid != '0) bad = 1;
    end
    checks++; if (bad) begin errors++; $display("FAIL withdraw_port1: got grant or response want none"); end
    next_cycle();
  endtask

  task automatic raise_random(input int excl);
    for (int p = 0; p < PORTS; p++) begin
      if (!m_pend[p] && p != excl && $urandom_range(0, 2) == 0) begin
        m_pend[p] = 1'b1;
        m_wr[p]   = 1'($urandom_range(0, 1));
        m_addr[p] = 10'($urandom);
        m_func[p] = 8'($urandom);
        m_data[p] = $urandom;
        m_be[p]   = 4'($urandom);
        set_req(p, m_wr[p], m_addr[p], m_func[p], m_data[p], m_be[p]);
      end
    end
  endtask

  task automatic test_random();
    int last = PORTS - 1;
    int w, lat;
    logic [31:0] rdata;
    bit ok;
    do_reset();
    m_pend = '0;
    for (int it = 0; it < 60; it++) begin
      raise_random(-1);
      sample();
      w = rr_pick(m_pend, last);
      checks++; if (s_req_ready !== onehot(w)) begin errors++; $display("FAIL rand_grant%0d: got %b want %b", it, s_req_ready, onehot(w)); end
      if (w < 0) begin next_cycle(); continue; end
      last = w;
      m_pend[w] = 1'b0;
      lat = $urandom_range(1, 4);
      rdata = $urandom;
      ok = 1;
      for (int k = 1; k <= lat; k++) begin
        next_cycle();
        if (k == 1) s_req_valid[w] = 1'b0;
        raise_random(w);
        if (k == lat) begin cfg_mgmt_read_write_done = 1'b1; cfg_mgmt_read_data = rdata; end
        sample();
        if (cfg_mgmt_addr !== m_addr[w] || cfg_mgmt_function_number !== m_func[w] || cfg_mgmt_write !== m_wr[w] ||
            cfg_mgmt_read !== !m_wr[w] || s_req_ready != '0 || s_resp_valid != '0) ok = 0;
        if (m_wr[w] && (cfg_mgmt_write_data !== m_data[w] || cfg_mgmt_byte_enable !== m_be[w])) ok = 0;
      end
      checks++; if (!ok) begin errors++; $display("FAIL rand_busy%0d: got addr %h rd %b wr %b want addr %h port %0d", it, cfg_mgmt_addr, cfg_mgmt_read, cfg_mgmt_write, m_addr[w], w); end
      next_cycle();
      cfg_mgmt_read_write_done = 1'b0;
      sample();
      checks++; if (s_resp_valid !== onehot(w) || s_resp_data !== (m_wr[w] ? 32'h0 : rdata) || s_resp_error !== '0 || cfg_mgmt_read || cfg_mgmt_write) begin errors++;
        $display("FAIL rand_resp%0d: got %b %h %b want %b %h 0", it, s_resp_valid, s_resp_data, s_resp_error, onehot(w), (m_wr[w] ? 32'h0 : rdata)); end
      next_cycle();
    end
    clear_inputs();
    next_cycle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_read();
    test_contention();
    test_write();
`ifdef PCIE_US_CFG_MGMT_ARB_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid_busy();
    test_withdrawn();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
